// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl
// ----------------------------------------------------------------------------
// Pipeline hazard controller for the 5-stage core. It generates the stall and
// flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and
// the EX-stage operand forwarding selects.
//
// Hazards handled, highest priority first:
//   1. Data-memory wait (MemReqM & ~MemReadyM, or still waiting in MEM_WAIT):
//      freeze PC..EX/MEM and bubble MEM/WB.
//   2. Taken branch / jump resolved in Execute (PCSrcE): flush IF/ID, ID/EX.
//   3. Load-use: hold PC and IF/ID for one cycle and bubble ID/EX.
// A watchdog bounds MEM_WAIT. After MEM_TIMEOUT consecutive MEM_WAIT cycles
// it sets the sticky MemErr flag and forces the FSM back to RUN.
//
// Parameters
//   LOAD_SRC     ResultSrc encoding that marks a load
//   MEM_TIMEOUT  MEM_WAIT cycles before the watchdog fires (1..65535)
//   CNT_W        performance counter width
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   Rs1D, Rs2D                 sources of the instruction in Decode
//   Rs1E, Rs2E                 sources of the instruction in Execute
//   RdE, RdM, RdW              destinations in Execute / Memory / Writeback
//   RegWriteE/M/W              destination write enables
//   ResultSrcE                 result select of the instruction in Execute
//   PCSrcE                     branch taken / jump in Execute
//   MemReqM, MemReadyM         data memory request / completion
//   StallF/D/E/M               hold PC, IF/ID, ID/EX, EX/MEM
//   FlushD/E/W                 bubble into IF/ID, ID/EX, MEM/WB
//   ForwardAE, ForwardBE       00 regfile, 01 from W, 10 from M
//   MemErr                     sticky watchdog flag
//   StallCnt/FlushCnt/WaitCnt  performance counters
//
// Build option
//   HAZARD_PERF_CNT_EN  when defined, the performance counters are built.
//                       Otherwise the counter outputs are tied to zero.
// ============================================================================
module hazard_ctrl #(
    parameter logic [1:0]  LOAD_SRC    = 2'b01,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic [CNT_W-1:0] WaitCnt
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [15:0] WD_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] wd_cnt;

    logic miss;
    logic lu;
    logic wd_fire;
    logic mem_hold;
    logic br_flush;

    // Forwarding select for one EX operand. The M stage is younger, so it wins.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       wr_m,
        input logic [4:0] rd_m,
        input logic       wr_w,
        input logic [4:0] rd_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return 2'b10;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    always_comb begin
        miss = MemReqM & ~MemReadyM;
        lu   = RegWriteE & (ResultSrcE == LOAD_SRC) & (RdE != 5'd0) &
               ((RdE == Rs1D) | (RdE == Rs2D));
        // This is the MEM_TIMEOUT-th MEM_WAIT cycle and memory is still busy.
        wd_fire  = (state == MEM_WAIT) & ~MemReadyM & (wd_cnt == WD_LAST);
        // Pipeline is frozen for memory this cycle. The watchdog cycle releases it.
        mem_hold = ((state == RUN) & miss) |
                   ((state == MEM_WAIT) & ~MemReadyM & ~wd_fire);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:      if (miss) state_nxt = MEM_WAIT;
            MEM_WAIT: if (MemReadyM || wd_fire) state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. Every control output is forced low while rst is high.
    // ------------------------------------------------------------------
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        br_flush  = 1'b0;
        if (!rst) begin
            if (mem_hold) begin
                // ID/EX is stalled, so a pending PCSrcE stays in Execute.
                // Its flush is issued on the exit cycle.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                // A dependent instruction in Decode is on the wrong path.
                // It is flushed, not stalled.
                FlushD   = 1'b1;
                FlushE   = 1'b1;
                br_flush = 1'b1;
            end else if (lu) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
            ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
            ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
        end
    end

    // ------------------------------------------------------------------
    // Watchdog counter and sticky error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            MemErr <= 1'b0;
        end else begin
            if ((state == MEM_WAIT) && (state_nxt == MEM_WAIT))
                wd_cnt <= wd_cnt + 16'd1;
            else
                wd_cnt <= '0;
            if (wd_fire)
                MemErr <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] wait_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            if (StallF)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (br_flush)
                flush_cnt_q <= flush_cnt_q + 1'b1;
            if (state == MEM_WAIT)
                wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
    assign WaitCnt  = wait_cnt_q;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
    assign WaitCnt  = '0;
`endif

endmodule
